// File: rtl/fpu_writeback_queue.sv
// FPU writeback queue. It captures FPU completions into a small FWFT FIFO and drains them to the register-file write port.
// It also flags RAW hazards against pending FP destinations. Optional flag tracking is enabled with FPU_WBQ_FLAGS_EN.
module fpu_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int RA_W   = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     fpu_sel,
    input  logic                     fpu_inprogress,
    input  logic [DATA_W-1:0]        fpu_result,
    input  logic [RA_W-1:0]          fpu_rd,
    input  logic                     fpu_dest_int,
`ifdef FPU_WBQ_FLAGS_EN
    input  logic [4:0]               fpu_flags,
    input  logic                     fflags_clr,
    output logic [4:0]               wb_flags,
    output logic [4:0]               fflags_sticky,
`endif
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DATA_W-1:0]        wb_data,
    output logic [RA_W-1:0]          wb_rd,
    output logic                     wb_dest_int,
    output logic                     wbq_stall,
    output logic [$clog2(DEPTH):0]   q_count,
    input  logic [RA_W-1:0]          rs1,
    input  logic [RA_W-1:0]          rs2,
    input  logic [RA_W-1:0]          rs3,
    output logic                     fp_hazard
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [RA_W-1:0]   rd_mem   [DEPTH];
    logic [DEPTH-1:0]  dint_mem;
    logic [DEPTH-1:0]  valid_mem;

    logic complete, drop, full, empty, push, pop;

    assign complete  = fpu_sel & ~fpu_inprogress;
    assign drop      = fpu_dest_int & (fpu_rd == '0);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop       = wb_valid & wb_ready;
    assign push      = complete & ~drop & (~full | pop);
    assign wbq_stall = complete & ~drop & full & ~pop;

    assign wb_valid    = ~empty;
    assign wb_data     = empty ? '0 : data_mem[rd_ptr];
    assign wb_rd       = empty ? '0 : rd_mem[rd_ptr];
    assign wb_dest_int = empty ? 1'b0 : dint_mem[rd_ptr];
    assign q_count     = count;

    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            valid_mem <= '0;
        end else begin
            if (pop) begin
                rd_ptr            <= rd_ptr + AW'(1);
                valid_mem[rd_ptr] <= 1'b0;
            end
            // When the queue is full, wr_ptr equals rd_ptr. Letting the push update come second makes its set win over the pop's clear.
            if (push) begin
                wr_ptr            <= wr_ptr + AW'(1);
                valid_mem[wr_ptr] <= 1'b1;
            end
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= fpu_result;
            rd_mem[wr_ptr]   <= fpu_rd;
            dint_mem[wr_ptr] <= fpu_dest_int;
        end
    end

    always_comb begin
        fp_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_mem[i] && !dint_mem[i] &&
                (rd_mem[i] == rs1 || rd_mem[i] == rs2 || rd_mem[i] == rs3))
                fp_hazard = 1'b1;
        end
        if (fpu_sel && fpu_inprogress && !fpu_dest_int &&
            (fpu_rd == rs1 || fpu_rd == rs2 || fpu_rd == rs3))
            fp_hazard = 1'b1;
    end

`ifdef FPU_WBQ_FLAGS_EN
    logic [4:0] flags_mem [DEPTH];

    assign wb_flags = empty ? 5'd0 : flags_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push)
            flags_mem[wr_ptr] <= fpu_flags;
    end

    // A clear and a pop in the same cycle restart accumulation from the popped flags.
    always_ff @(posedge clock) begin
        if (clear)
            fflags_sticky <= 5'd0;
        else if (pop)
            fflags_sticky <= (fflags_clr ? 5'd0 : fflags_sticky) | wb_flags;
        else if (fflags_clr)
            fflags_sticky <= 5'd0;
    end
`endif

endmodule

// File: tb/tb_fpu_writeback_queue.sv
// Self-checking bench for fpu_writeback_queue. It runs directed vectors, hand-written corner sequences, and random traffic against a queue model.
module tb_fpu_writeback_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int RA_W   = 5;

    logic              clock = 1'b0;
    logic              clear = 1'b0;
    logic              fpu_sel = 1'b0, fpu_inprogress = 1'b0, fpu_dest_int = 1'b0;
    logic [DATA_W-1:0] fpu_result = '0;
    logic [RA_W-1:0]   fpu_rd = '0;
    logic              wb_valid, wb_dest_int, wbq_stall, fp_hazard;
    logic              wb_ready = 1'b0;
    logic [DATA_W-1:0] wb_data;
    logic [RA_W-1:0]   wb_rd;
    logic [2:0]        q_count;
    logic [RA_W-1:0]   rs1 = 5'd31, rs2 = 5'd31, rs3 = 5'd31;
`ifdef FPU_WBQ_FLAGS_EN
    logic [4:0]        fpu_flags = '0;
    logic              fflags_clr = 1'b0;
    logic [4:0]        wb_flags, fflags_sticky;
`endif

    int passed = 0;
    int total  = 0;

    fpu_writeback_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RA_W(RA_W)) dut (
        .clock(clock), .clear(clear),
        .fpu_sel(fpu_sel), .fpu_inprogress(fpu_inprogress),
        .fpu_result(fpu_result), .fpu_rd(fpu_rd), .fpu_dest_int(fpu_dest_int),
`ifdef FPU_WBQ_FLAGS_EN
        .fpu_flags(fpu_flags), .fflags_clr(fflags_clr),
        .wb_flags(wb_flags), .fflags_sticky(fflags_sticky),
`endif
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_dest_int(wb_dest_int), .wbq_stall(wbq_stall),
        .q_count(q_count), .rs1(rs1), .rs2(rs2), .rs3(rs3), .fp_hazard(fp_hazard)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: a plain queue of pending entries
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [RA_W-1:0]   rd;
        logic              dint;
        logic [4:0]        flags;
    } ent_t;
    ent_t       mq[$];
    logic [4:0] m_sticky = '0;

    task automatic do_reset();
        clear = 1'b1; fpu_sel = 1'b0; fpu_inprogress = 1'b0; wb_ready = 1'b0;
        fpu_dest_int = 1'b0; fpu_rd = '0;
        rs1 = 5'd31; rs2 = 5'd31; rs3 = 5'd31;
`ifdef FPU_WBQ_FLAGS_EN
        fflags_clr = 1'b0; fpu_flags = '0;
`endif
        tick();
        clear = 1'b0;
        mq.delete();
        m_sticky = '0;
    endtask

    // One model-checked cycle with the inputs currently driven
    task automatic step();
        logic comp, drp, e_pop, e_push, e_stall, e_haz, full;
        logic [4:0] fl;
        ent_t e;
        @(negedge clock);
        full    = (mq.size() == DEPTH);
        comp    = fpu_sel & ~fpu_inprogress;
        drp     = fpu_dest_int && fpu_rd == 0;
        e_pop   = (mq.size() > 0) && wb_ready;
        e_push  = comp && !drp && (!full || e_pop);
        e_stall = comp && !drp && full && !e_pop;
        e_haz   = fpu_sel && fpu_inprogress && !fpu_dest_int &&
                  (fpu_rd == rs1 || fpu_rd == rs2 || fpu_rd == rs3);
        foreach (mq[i])
            if (!mq[i].dint && (mq[i].rd == rs1 || mq[i].rd == rs2 || mq[i].rd == rs3))
                e_haz = 1'b1;
        chk("wb_valid", 64'(wb_valid), 64'(mq.size() > 0));
        chk("q_count", 64'(q_count), 64'(mq.size()));
        chk("wbq_stall", 64'(wbq_stall), 64'(e_stall));
        chk("fp_hazard", 64'(fp_hazard), 64'(e_haz));
        chk("wb_data", 64'(wb_data), 64'(mq.size() > 0 ? mq[0].data : '0));
        chk("wb_rd", 64'(wb_rd), 64'(mq.size() > 0 ? mq[0].rd : '0));
        chk("wb_dest_int", 64'(wb_dest_int), 64'(mq.size() > 0 ? mq[0].dint : 1'b0));
        fl = (mq.size() > 0) ? mq[0].flags : 5'd0;
        e.data = fpu_result; e.rd = fpu_rd; e.dint = fpu_dest_int; e.flags = '0;
`ifdef FPU_WBQ_FLAGS_EN
        e.flags = fpu_flags;
        chk("wb_flags", 64'(wb_flags), 64'(fl));
        chk("fflags_sticky", 64'(fflags_sticky), 64'(m_sticky));
`endif
        @(posedge clock);
        if (clear) begin
            mq.delete();
            m_sticky = '0;
        end else begin
`ifdef FPU_WBQ_FLAGS_EN
            if (e_pop)
                m_sticky = (fflags_clr ? 5'd0 : m_sticky) | fl;
            else if (fflags_clr)
                m_sticky = '0;
`endif
            if (e_pop)  void'(mq.pop_front());
            if (e_push) mq.push_back(e);
        end
        #1;
    endtask

    typedef struct {
        logic        sel, ip, dint, ready;
        logic [4:0]  rd, rs2v;
        logic [31:0] res;
        logic        x_valid, x_stall, x_haz;
        logic [2:0]  x_cnt;
        logic [4:0]  x_rd;
        logic [31:0] x_data;
    } vec_t;

    function automatic vec_t mk(logic sel, logic ip, logic dint, logic ready, logic [4:0] rd,
                                logic [4:0] rs2v, logic [31:0] res, logic xv, logic xs, logic xh,
                                logic [2:0] xc, logic [4:0] xrd, logic [31:0] xd);
        vec_t v;
        v.sel = sel; v.ip = ip; v.dint = dint; v.ready = ready; v.rd = rd; v.rs2v = rs2v;
        v.res = res; v.x_valid = xv; v.x_stall = xs; v.x_haz = xh; v.x_cnt = xc;
        v.x_rd = xrd; v.x_data = xd;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        tbl[0]  = mk(1,0,0,1, 3,31,32'h3F800000, 0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,1, 0,31,0,            1,0,0,1,3,32'h3F800000);
        tbl[2]  = mk(0,0,0,0, 0,31,0,            0,0,0,0,0,0);
        tbl[3]  = mk(1,0,0,0, 1,31,32'h101,      0,0,0,0,0,0);
        tbl[4]  = mk(1,0,0,0, 2,31,32'h102,      1,0,0,1,1,32'h101);
        tbl[5]  = mk(1,0,0,0, 3,31,32'h103,      1,0,0,2,1,32'h101);
        tbl[6]  = mk(1,0,0,0, 4,31,32'h104,      1,0,0,3,1,32'h101);
        tbl[7]  = mk(1,0,0,0, 5,31,32'h105,      1,1,0,4,1,32'h101);
        tbl[8]  = mk(1,0,0,1, 5,31,32'h105,      1,0,0,4,1,32'h101);
        tbl[9]  = mk(1,0,1,0, 0,31,32'hDEAD,     1,0,0,4,2,32'h102);
        tbl[10] = mk(0,0,0,1, 0, 4,0,            1,0,1,4,2,32'h102);
        tbl[11] = mk(0,0,0,1, 0,31,0,            1,0,0,3,3,32'h103);
        tbl[12] = mk(0,0,0,1, 0,31,0,            1,0,0,2,4,32'h104);
        tbl[13] = mk(0,0,0,1, 0,31,0,            1,0,0,1,5,32'h105);
        tbl[14] = mk(0,0,0,0, 0, 0,0,            0,0,0,0,0,0);

        do_reset();
        @(negedge clock);
        chk("reset_valid", 64'(wb_valid), 64'd0);
        chk("reset_count", 64'(q_count), 64'd0);
        chk("reset_data", 64'(wb_data), 64'd0);
        tick();

        foreach (tbl[i]) begin
            fpu_sel = tbl[i].sel; fpu_inprogress = tbl[i].ip; fpu_dest_int = tbl[i].dint;
            wb_ready = tbl[i].ready; fpu_rd = tbl[i].rd; rs2 = tbl[i].rs2v;
            fpu_result = tbl[i].res;
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), 64'(wb_valid), 64'(tbl[i].x_valid));
            chk($sformatf("vec%0d_stall", i), 64'(wbq_stall), 64'(tbl[i].x_stall));
            chk($sformatf("vec%0d_hazard", i), 64'(fp_hazard), 64'(tbl[i].x_haz));
            chk($sformatf("vec%0d_count", i), 64'(q_count), 64'(tbl[i].x_cnt));
            chk($sformatf("vec%0d_rd", i), 64'(wb_rd), 64'(tbl[i].x_rd));
            chk($sformatf("vec%0d_data", i), 64'(wb_data), 64'(tbl[i].x_data));
            tick();
        end

        // Hazard sequences: FP entry, integer-file entry, and in-flight operation
        do_reset();
        fpu_sel = 1; fpu_rd = 7; fpu_dest_int = 0; fpu_result = 32'h7;
        tick();
        fpu_sel = 0; rs2 = 7;
        @(negedge clock); chk("haz_fp_entry", 64'(fp_hazard), 64'd1);
        do_reset();
        fpu_sel = 1; fpu_rd = 7; fpu_dest_int = 1;
        tick();
        fpu_sel = 0; fpu_dest_int = 0; rs2 = 7;
        @(negedge clock); chk("haz_int_entry", 64'(fp_hazard), 64'd0);
        fpu_sel = 1; fpu_inprogress = 1; fpu_rd = 9; rs1 = 9; rs2 = 0;
        @(negedge clock); chk("haz_inflight", 64'(fp_hazard), 64'd1);
        fpu_dest_int = 1;
        @(negedge clock); chk("haz_inflight_int", 64'(fp_hazard), 64'd0);
        tick();

        // Clear while draining discards all entries
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fpu_sel = 1; fpu_rd = 5'(10 + k); fpu_result = 32'(k + 1);
`ifdef FPU_WBQ_FLAGS_EN
            fpu_flags = (k == 0) ? 5'h01 : 5'h10;
`endif
            tick();
        end
        fpu_sel = 0;
        @(negedge clock); chk("three_queued", 64'(q_count), 64'd3);
        tick();
`ifdef FPU_WBQ_FLAGS_EN
        wb_ready = 1;
        tick(); tick();
        wb_ready = 0;
        @(negedge clock); chk("sticky_accum", 64'(fflags_sticky), 64'h11);
        tick();
`endif
        clear = 1; wb_ready = 1;
        tick();
        clear = 0; wb_ready = 0;
        @(negedge clock);
        chk("clear_valid", 64'(wb_valid), 64'd0);
        chk("clear_count", 64'(q_count), 64'd0);
        chk("clear_rd", 64'(wb_rd), 64'd0);
`ifdef FPU_WBQ_FLAGS_EN
        chk("clear_sticky", 64'(fflags_sticky), 64'd0);
`endif
        tick();

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            fpu_sel        = ($urandom_range(0, 3) != 0);
            fpu_inprogress = ($urandom_range(0, 2) == 0);
            fpu_dest_int   = ($urandom_range(0, 3) == 0);
            fpu_rd         = 5'($urandom_range(0, 7));
            fpu_result     = $urandom;
            wb_ready       = ($urandom_range(0, 1) == 1);
            rs1            = 5'($urandom_range(0, 7));
            rs2            = 5'($urandom_range(0, 7));
            rs3            = 5'($urandom_range(0, 7));
            clear          = ($urandom_range(0, 99) == 0);
`ifdef FPU_WBQ_FLAGS_EN
            fpu_flags      = 5'($urandom_range(0, 31));
            fflags_clr     = ($urandom_range(0, 7) == 0);
`endif
            step();
        end
        clear = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
